outbox_uart_tx: RTL and testbench
=================================

// Module: outbox_uart_tx
// PURPOSE
//  Drains the CPU OUTBOX FIFO (cpu_out_data / cpu_out_empty / cpu_out_rd) and
//  serialises each popped byte onto a UART TX line, 8N1, LSB first.
//  Sits directly downstream of the CPU top level, between it and the board pin.
//  Pops exactly one FIFO entry per transmitted value; never pops when empty.
// PARAMETERS
//  BAUD_DIV  104  clock cycles per UART bit (12 MHz / 115200); legal range 2..65535
// PORTS
//  clk          in   1  system clock; all logic on the rising edge
//  i_rst        in   1  synchronous, active-high reset
//  i_en         in   1  drain enable; 0 = start no new value (current frame completes)
//  i_out_empty  in   1  OUTBOX empty flag (cpu_out_empty)
//  i_out_data   in   8  OUTBOX head data (cpu_out_data), valid while i_out_empty=0
//  o_out_rd     out  1  one-cycle pop strobe to OUTBOX (drives cpu_out_rd)
//  o_tx         out  1  UART TX line, idle high
//  o_busy       out  1  1 while any character of the current value is being sent
// BEHAVIOUR
//  Reset (i_rst=1 at an edge): state=IDLE, o_tx=1, o_busy=0, bit and baud counters=0,
//   shift register=0. o_out_rd is forced 0 while i_rst=1.
//  FSM states: IDLE, START, DATA, STOP.
//  IDLE:  o_out_rd = i_en & ~i_out_empty & ~i_rst (combinational, same cycle).
//   On the edge where o_out_rd=1: latch i_out_data, go to START, o_busy<=1.
//   The FIFO pops on that same edge. Later changes on i_out_data do not affect the frame.
//  START: o_tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
//  DATA:  o_tx=shift[idx] for BAUD_DIV cycles each, idx 0..7. After idx 7, go to STOP.
//  STOP:  o_tx=1 for BAUD_DIV cycles. Then:
//   - if more characters of the same value remain, go to START;
//   - otherwise go to IDLE and set o_busy<=0.
//  Frame length is 10*BAUD_DIV cycles. o_tx first goes low on the edge after the pop.
//  Back-to-back values: at least 1 IDLE cycle between the end of STOP and the next pop.
//  o_out_rd is asserted only in IDLE. It is never high on 2 consecutive cycles.
//  It is never high while i_out_empty=1.
//  i_en falling mid-frame: the frame and any remaining characters of the value finish.
//   No further pop occurs until i_en=1.
//  Reset mid-frame: abort. o_tx=1 from the next edge. The popped value is discarded.
//  The baud counter is 16 bits. It counts 0..BAUD_DIV-1 and wraps to 0 at each
//   bit boundary.
//  o_tx, o_busy and the state are registered. o_tx is glitch-free.
// CONFIGURATION
//  OUTBOX_TX_HEX_EN defined: each popped byte is sent as 3 characters:
//   upper-case ASCII hex of the high nibble, then the low nibble, then 0x0A.
//   Digits map 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46.
//   There is one pop per 3 characters. o_busy stays 1 across all 3 characters.
//  OUTBOX_TX_HEX_EN undefined: the raw byte is sent as exactly 1 character.
//   The hex encoder and character counter are not synthesised.
// TESTING (BAUD_DIV=4 unless stated)
//  1. Raw mode, push 0x55 -> one o_out_rd pulse. Next edge o_tx low 4 cycles, then
//   1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles. o_busy high for 40 cycles.
//  2. Raw mode, push 0xA5 then 0x0F -> exactly 2 pops. Frames decode 0xA5, 0x0F.
//   Exactly 1 idle-high cycle between frames.
//  3. FIFO empty with i_en=1 for 200 cycles -> o_out_rd never 1, o_tx constant 1,
//   o_busy 0.
//  4. Assert i_rst for 1 cycle at cycle 15 of a 0xFF frame -> o_tx=1 and o_busy=0
//   from the next edge. No pop occurs during reset. The next queued byte sends cleanly.
//  5. i_en=0 at cycle 10 of a frame with 2 bytes queued -> the frame completes and no
//   second pop happens. Setting i_en=1 then pops and sends byte 2.
//  6. OUTBOX_TX_HEX_EN, push 0x3C -> 1 pop. Characters 0x33, 0x43, 0x0A are sent
//   back-to-back in 120 cycles, with o_busy high throughout.

Source files
------------

// File: rtl/outbox_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : outbox_uart_tx
// Description : Drains the CPU OUTBOX FIFO and serialises each popped byte
//               onto a UART TX line (8N1, LSB first, idle high).
//               Optional build macro OUTBOX_TX_HEX_EN: each byte is sent as
//               two upper-case ASCII hex digits followed by 0x0A.
// Revision    : 1.0 - initial release
// ============================================================================
module outbox_uart_tx #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_out_empty,
    input  logic [7:0] i_out_data,
    output logic       o_out_rd,
    output logic       o_tx,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] c_BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t      r_state,  w_state_nxt;
    logic [15:0] r_baud,   w_baud_nxt;
    logic [2:0]  r_idx,    w_idx_nxt;
    logic [7:0]  r_shift,  w_shift_nxt;
    logic        r_tx,     w_tx_nxt;
    logic        r_busy,   w_busy_nxt;
    logic        w_pop;
    logic        w_baud_last;

`ifdef OUTBOX_TX_HEX_EN
    // Character index within the current value (0 = high digit, 1 = low digit, 2 = LF)
    logic [1:0]  r_char,   w_char_nxt;
    // Low nibble kept until its character is loaded into the shifter
    logic [3:0]  r_lo,     w_lo_nxt;

    function automatic logic [7:0] f_hex(input logic [3:0] i_nib);
        if (i_nib < 4'd10) begin
            return 8'h30 + {4'h0, i_nib};
        end
        return 8'h37 + {4'h0, i_nib};
    endfunction
`endif

    // Pop only from IDLE; reset masks the strobe so the FIFO cannot lose a byte
    assign w_pop       = (r_state == S_IDLE) & i_en & ~i_out_empty & ~i_rst;
    assign w_baud_last = (r_baud == c_BAUD_LAST);

    assign o_out_rd = w_pop;
    assign o_tx     = r_tx;
    assign o_busy   = r_busy;

    // Next-state and next-output logic; o_tx is computed here and registered
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
`ifdef OUTBOX_TX_HEX_EN
        w_char_nxt  = r_char;
        w_lo_nxt    = r_lo;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = 16'd0;
                w_idx_nxt  = 3'd0;
                w_tx_nxt   = 1'b1;
                if (w_pop) begin
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
`ifdef OUTBOX_TX_HEX_EN
                    w_shift_nxt = f_hex(i_out_data[7:4]);
                    w_lo_nxt    = i_out_data[3:0];
                    w_char_nxt  = 2'd0;
`else
                    w_shift_nxt = i_out_data;
`endif
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt  = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = 16'd0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_tx_nxt    = r_shift[r_idx + 3'd1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt = 16'd0;
`ifdef OUTBOX_TX_HEX_EN
                    if (r_char != 2'd2) begin
                        // Next character of the same value follows without an idle gap
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                        w_char_nxt  = r_char + 2'd1;
                        w_shift_nxt = (r_char == 2'd0) ? f_hex(r_lo) : 8'h0A;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
`else
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
`endif
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef OUTBOX_TX_HEX_EN
            r_char  <= 2'd0;
            r_lo    <= 4'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
`ifdef OUTBOX_TX_HEX_EN
            r_char  <= w_char_nxt;
            r_lo    <= w_lo_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_outbox_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_outbox_uart_tx
// Description : Self-checking bench for outbox_uart_tx with a FIFO model,
//               a cycle-level UART receiver and an expected-character queue.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_outbox_uart_tx;

    localparam int BD  = 4;
`ifdef OUTBOX_TX_HEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 1;
`endif
    localparam int FRAME = 10 * BD;

    logic       clk = 1'b0;
    logic       i_rst, i_en, i_out_empty;
    logic [7:0] i_out_data;
    logic       o_out_rd, o_tx, o_busy;

    outbox_uart_tx #(.BAUD_DIV(BD)) u_dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_out_empty (i_out_empty),
        .i_out_data  (i_out_data),
        .o_out_rd    (o_out_rd),
        .o_tx        (o_tx),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_err = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int        start_q[$];
    int        n_pops = 0, n_frames = 0, n_pushed = 0, viol = 0, cyc = 0;
    logic      rx_act = 1'b0;
    int        rx_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_ch(input logic [3:0] n);
        logic [7:0] lut [16];
        lut = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return lut[n];
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        n_pushed++;
    endtask

    // FIFO model, pop-side scoreboard feed, UART receiver and protocol monitor
    initial begin
        logic       rd_seen, prev_rd;
        logic [7:0] b, rx_byte;
        int         busy_run;
        prev_rd = 1'b0; busy_run = 0; rx_byte = 8'h00;
        i_out_empty = 1'b1; i_out_data = 8'h00;
        forever begin
            @(negedge clk); #1;
            cyc++;
            rd_seen = o_out_rd;
            if (o_out_rd && i_out_empty) viol++;
            if (o_out_rd && prev_rd)     viol++;
            if (o_out_rd && o_busy)      viol++;
            prev_rd = o_out_rd;
            if (i_rst) begin
                rx_act = 1'b0;
                exp_q.delete();
                busy_run = 0;
            end else begin
                if (o_busy) busy_run++;
                else if (busy_run != 0) begin
                    chk("busy_len", busy_run, FRAME * NCH);
                    busy_run = 0;
                end
                if (!rx_act) begin
                    if (o_tx == 1'b0) begin
                        rx_act = 1'b1;
                        rx_cnt = 0;
                        start_q.push_back(cyc);
                    end
                end else begin
                    rx_cnt++;
                    if (rx_cnt == BD / 2 && o_tx !== 1'b0) viol++;
                    if (rx_cnt >= BD + BD / 2 && rx_cnt < 9 * BD && (rx_cnt % BD) == BD / 2)
                        rx_byte[(rx_cnt - BD) / BD] = o_tx;
                    if (rx_cnt == 9 * BD + BD / 2) begin
                        chk("stop_bit", o_tx, 1);
                        if (exp_q.size() == 0) chk("unexpected_frame", rx_byte, 32'hFFFF_FFFF);
                        else                   chk("frame", rx_byte, exp_q.pop_front());
                        n_frames++;
                        rx_act = 1'b0;
                    end
                end
            end
            @(posedge clk); #1;
            if (rd_seen) begin
                b = fifo_q.pop_front();
                n_pops++;
`ifdef OUTBOX_TX_HEX_EN
                exp_q.push_back(hex_ch(b[7:4]));
                exp_q.push_back(hex_ch(b[3:0]));
                exp_q.push_back(8'h0A);
`else
                exp_q.push_back(b);
`endif
            end
            i_out_empty = (fifo_q.size() == 0);
            i_out_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((fifo_q.size() != 0 || o_busy || rx_act) && k < budget);
        chk("idle_in_time", k < budget, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_frame_cycle(input int s0, input int at);
        int k;
        k = 0;
        while (!(start_q.size() > s0 && rx_act && rx_cnt >= at) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_seen", k < 2000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, pops0, k, s0;
        i_rst = 1'b1;
        i_en  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_rd", o_out_rd, 0);
        @(negedge clk);
        i_rst = 1'b0;
        i_en  = 1'b1;

        // Empty FIFO with drain enabled: nothing moves
        bad = 0;
        repeat (200) begin
            @(negedge clk); #1;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_out_rd !== 1'b0) bad++;
        end
        chk("empty_idle", bad, 0);

        // Single byte
        pops0 = n_pops;
        @(negedge clk);
        push(8'h55);
        wait_idle(2000);
        chk("t1_pops", n_pops - pops0, 1);

        // Two queued bytes, one idle cycle between values
        pops0 = n_pops;
        push(8'hA5);
        push(8'h0F);
        wait_idle(2000);
        chk("t2_pops", n_pops - pops0, 2);
        chk("t2_gap", start_q[start_q.size() - 1] - start_q[start_q.size() - 1 - NCH],
            FRAME * NCH + 1);

        // Reset mid-frame aborts the value, next byte still goes out
        pops0 = n_pops;
        s0 = start_q.size();
        push(8'hFF);
        push(8'h12);
        wait_frame_cycle(s0, 14);
        @(negedge clk);
        i_rst = 1'b1;
        #1 chk("t4_rd_in_rst", o_out_rd, 0);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        chk("t4_tx_after_rst", o_tx, 1);
        chk("t4_busy_after_rst", o_busy, 0);
        wait_idle(2000);
        chk("t4_pops", n_pops - pops0, 2);

        // Reset while idle with data waiting must mask the pop strobe
        i_en = 1'b0;
        push(8'h7E);
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        i_en  = 1'b1;
        #1 chk("rst_masks_rd", o_out_rd, 0);
        @(negedge clk);
        i_rst = 1'b0;
        wait_idle(2000);

        // Drain disabled mid-frame: current value completes, no second pop
        pops0 = n_pops;
        s0 = start_q.size();
        push(8'hC3);
        push(8'h5A);
        wait_frame_cycle(s0, 10);
        @(negedge clk);
        i_en = 1'b0;
        k = 0;
        while (o_busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("t5_busy_drops", k < 1000, 1);
        repeat (20) @(negedge clk);
        chk("t5_one_pop", n_pops - pops0, 1);
        chk("t5_fifo_left", fifo_q.size(), 1);
        i_en = 1'b1;
        wait_idle(2000);
        chk("t5_pops", n_pops - pops0, 2);

        // 0x3C: raw byte, or "3C\n" in hex mode
        pops0 = n_pops;
        push(8'h3C);
        wait_idle(2000);
        chk("t6_pops", n_pops - pops0, 1);
`ifdef OUTBOX_TX_HEX_EN
        chk("t6_char_span", start_q[start_q.size() - 1] - start_q[start_q.size() - 3], 2 * FRAME);
`endif

        chk("exp_drained", exp_q.size(), 0);
        chk("protocol_viol", viol, 0);
        chk("frames_total", n_frames, NCH * (n_pushed - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
